// File: rtl/spi_sram_pkg.sv
// Shared constants and types for the SPI SRAM emulator.
// Covers the 23LC-style command bytes, mode register encodings and bus FSM states.
package spi_sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDMR  = 8'h05;
  localparam logic [7:0] CMD_WRMR  = 8'h01;

  // mode register bits [7:6]; 2'b11 behaves as sequential
  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  localparam logic [7:0] MODE_RESET = {MODE_SEQ, 6'b000000};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD,
    ST_WR,
    ST_RDMR,
    ST_WRMR,
    ST_IGNORE
  } bus_state_t;

endpackage

// File: rtl/spi_sram_emu_if.sv
// Debug port of the SPI SRAM emulator: 32-bit little-endian preload/inspect access.
// The master side issues one-cycle rd/wr requests; the slave side reports busy/valid.
interface spi_sram_emu_if #(
  parameter int AW = 24
);

  logic [AW-1:0] dbg_addr;
  logic          dbg_rd;
  logic          dbg_wr;
  logic [31:0]   dbg_wdata;
  logic [31:0]   dbg_rdata;
  logic          dbg_valid;
  logic          busy;

  modport master (
    output dbg_addr, dbg_rd, dbg_wr, dbg_wdata,
    input  dbg_rdata, dbg_valid, busy
  );

  modport slave (
    input  dbg_addr, dbg_rd, dbg_wr, dbg_wdata,
    output dbg_rdata, dbg_valid, busy
  );

endinterface

// File: rtl/spi_sram_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin plus rise/fall pulse detect.
// RST_VAL is the idle level of the pin so reset never produces a false edge.
module spi_sram_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_sram_emu.sv
// SPI SRAM emulator: oversampled mode-0 slave with READ/WRITE/RDMR/WRMR and a debug port.
// One single-port byte array; SPI commits and prefetches win over debug accesses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | deselected, waiting for select to fall
// ST_CMD    | shifting in the command byte
// ST_ADDR   | shifting in ADDR_BYTES address bytes, MSB first
// ST_RD     | streaming memory bytes out on MISO
// ST_WR     | committing each received byte to memory
// ST_RDMR   | repeatedly shifting out the mode register
// ST_WRMR   | receiving the new mode register byte
// ST_IGNORE | dropping traffic until deselect
module spi_sram_emu
  import spi_sram_pkg::*;
#(
  parameter int ADDR_BYTES = 3,
  parameter int DEPTH_LOG2 = 12,
  parameter int PAGE_LOG2  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic spi_select,
  input  logic spi_mosi,
  output logic spi_miso,
  spi_sram_emu_if.slave dbg
);

  localparam int DL  = DEPTH_LOG2;
  localparam int ABW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  logic clk_rise, clk_fall, sel_rise, sel_fall;
  logic mosi_s1, mosi_s2;

  spi_sram_sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst(rst), .din(spi_clk), .rise(clk_rise), .fall(clk_fall)
  );

  spi_sram_sync_edge #(.RST_VAL(1'b1)) u_sync_sel (
    .clk(clk), .rst(rst), .din(spi_select), .rise(sel_rise), .fall(sel_fall)
  );

  // same two-flop depth as spi_clk so data lines up with the rise pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  bus_state_t         state;
  logic [2:0]         bit_cnt;
  logic [ABW-1:0]     abyte_cnt;
  logic               is_read;
  logic [6:0]         shift_in;
  logic [DL-1:0]      addr;
  logic [7:0]         mode;
  logic [7:0]         cur_byte;
  logic               miso_q;
  logic               spi_rd_req, spi_wr_req;
  logic [DL-1:0]      spi_idx;
  logic [7:0]         spi_wd;

  logic [7:0]         mem [0:(1<<DL)-1];
  logic [DL-1:0]      mem_idx;
  logic [7:0]         mem_wd;
  logic [7:0]         mem_rd;
  logic               mem_we;
  logic               spi_req;

  logic               busy_q, valid_q, dbg_is_wr;
  logic [1:0]         dbg_left;
  logic [DL-1:0]      dbg_cur;
  logic [31:0]        dbg_wd_q;
  logic [23:0]        dbg_acc;
  logic [31:0]        rdata_q;
  logic               dbg_go;

  function automatic logic [DL-1:0] addr_adv(input logic [DL-1:0] a, input logic [1:0] m);
    logic [DL-1:0] n;
    n = a + DL'(1);
    if (m == MODE_PAGE) n = {a[DL-1:PAGE_LOG2], a[PAGE_LOG2-1:0] + PAGE_LOG2'(1)};
    return n;
  endfunction

  logic [7:0]    shift_nxt;
  logic [DL-1:0] addr_shift_nxt;
  logic [DL-1:0] addr_nxt;
  logic          byte_mode;

  assign shift_nxt      = {shift_in, mosi_s2};
  assign addr_shift_nxt = {addr[DL-2:0], mosi_s2};
  assign addr_nxt       = addr_adv(addr, mode[7:6]);
  assign byte_mode      = (mode[7:6] == MODE_BYTE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      abyte_cnt  <= '0;
      is_read    <= 1'b0;
      shift_in   <= 7'd0;
      addr       <= '0;
      mode       <= MODE_RESET;
      cur_byte   <= 8'h00;
      miso_q     <= 1'b0;
      spi_rd_req <= 1'b0;
      spi_wr_req <= 1'b0;
      spi_idx    <= '0;
      spi_wd     <= 8'h00;
    end else begin
      spi_rd_req <= 1'b0;
      spi_wr_req <= 1'b0;
      if (spi_rd_req) cur_byte <= mem_rd;

      if (sel_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= 3'd0;
        miso_q  <= 1'b0;
      end else if (sel_fall) begin
        state     <= ST_CMD;
        bit_cnt   <= 3'd0;
        abyte_cnt <= '0;
        shift_in  <= 7'd0;
        miso_q    <= 1'b0;
      end else if (state != ST_IDLE && clk_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_in <= shift_nxt[6:0];
        if (state == ST_ADDR) addr <= addr_shift_nxt;
        if (bit_cnt == 3'd7) begin
          case (state)
            ST_CMD: begin
              abyte_cnt <= '0;
              case (shift_nxt)
                CMD_READ:  begin state <= ST_ADDR; is_read <= 1'b1; end
                CMD_WRITE: begin state <= ST_ADDR; is_read <= 1'b0; end
                CMD_RDMR:  state <= ST_RDMR;
                CMD_WRMR:  state <= ST_WRMR;
                default:   state <= ST_IGNORE;
              endcase
            end
            ST_ADDR: begin
              abyte_cnt <= abyte_cnt + ABW'(1);
              if (abyte_cnt == ABW'(ADDR_BYTES - 1)) begin
                if (is_read) begin
                  state      <= ST_RD;
                  spi_rd_req <= 1'b1;
                  spi_idx    <= addr_shift_nxt;
                end else begin
                  state <= ST_WR;
                end
              end
            end
            ST_RD: begin
              if (byte_mode) begin
                state  <= ST_IGNORE;
                miso_q <= 1'b0;
              end else begin
                addr       <= addr_nxt;
                spi_rd_req <= 1'b1;
                spi_idx    <= addr_nxt;
              end
            end
            ST_WR: begin
              spi_wr_req <= 1'b1;
              spi_idx    <= addr;
              spi_wd     <= shift_nxt;
              if (byte_mode) state <= ST_IGNORE;
              else           addr  <= addr_nxt;
            end
            ST_WRMR: begin
              mode  <= shift_nxt;
              state <= ST_IGNORE;
            end
            default: ;
          endcase
        end
      end else if (state != ST_IDLE && clk_fall) begin
        case (state)
          ST_RD:   miso_q <= cur_byte[~bit_cnt];
          ST_RDMR: miso_q <= mode[~bit_cnt];
          default: miso_q <= 1'b0;
        endcase
      end
    end
  end

  assign spi_miso = miso_q;

  always_comb begin
    spi_req = spi_rd_req | spi_wr_req;
    dbg_go  = busy_q & ~spi_req;
    mem_idx = spi_req ? spi_idx : dbg_cur;
    mem_wd  = spi_wr_req ? spi_wd : dbg_wd_q[7:0];
    mem_we  = spi_wr_req | (dbg_go & dbg_is_wr & ~rst);
  end

  assign mem_rd = mem[mem_idx];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wd;
  end

  // dbg_left counts the remaining byte accesses down to the terminal 0
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      dbg_is_wr <= 1'b0;
      dbg_left  <= 2'd0;
      dbg_cur   <= '0;
      dbg_wd_q  <= 32'h0;
      dbg_acc   <= 24'h0;
      rdata_q   <= 32'h0;
    end else begin
      valid_q <= 1'b0;
      if (!busy_q) begin
        if (dbg.dbg_rd ^ dbg.dbg_wr) begin
          busy_q    <= 1'b1;
          dbg_is_wr <= dbg.dbg_wr;
          dbg_cur   <= dbg.dbg_addr[DL-1:0];
          dbg_wd_q  <= dbg.dbg_wdata;
          dbg_left  <= 2'd3;
        end
      end else if (dbg_go) begin
        dbg_cur  <= dbg_cur + DL'(1);
        dbg_wd_q <= {8'h00, dbg_wd_q[31:8]};
        dbg_acc  <= {mem_rd, dbg_acc[23:8]};
        dbg_left <= dbg_left - 2'd1;
        if (dbg_left == 2'd0) begin
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          if (!dbg_is_wr) rdata_q <= {mem_rd, dbg_acc};
        end
      end
    end
  end

  assign dbg.busy      = busy_q;
  assign dbg.dbg_valid = valid_q;
  assign dbg.dbg_rdata = rdata_q;

  logic unused_dbg_addr;
  assign unused_dbg_addr = ^dbg.dbg_addr;

endmodule

// File: doc/spi_sram_emu.md
# spi_sram_emu

Synthesisable, parametrised SPI SRAM emulator (23LC-style command set) that stands in for the external SPI RAM next to the CPU in simulation and FPGA bring-up. It oversamples the SPI bus on the system clock. It supports READ, WRITE and mode-register commands with byte, page and sequential addressing. It also has a 32-bit debug port for preloading and inspecting memory. It replaces the read-mostly, SPI-clocked RAM model.

## Interface
Parameters:
- ADDR_BYTES, 3, address bytes sent after the command (address width AW = 8*ADDR_BYTES)
- DEPTH_LOG2, 12, log2 of memory size in bytes; address bits at and above DEPTH_LOG2 are ignored
- PAGE_LOG2, 5, log2 of page size for page mode

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- spi_clk  in  1  SPI clock from master, mode 0; period ≥ 8 clk cycles
- spi_select  in  1  chip select, active low
- spi_mosi  in  1  master-out data
- spi_miso  out  1  slave-out data
- dbg_addr  in  AW  debug byte address
- dbg_rd  in  1  one-cycle request: read 4 bytes
- dbg_wr  in  1  one-cycle request: write 4 bytes
- dbg_wdata  in  32  write data, little-endian (byte 0 = bits 7:0 at dbg_addr)
- dbg_rdata  out  32  read data, little-endian
- dbg_valid  out  1  one-cycle pulse: debug op complete
- busy  out  1  debug op in progress

## Operation
- spi_clk, spi_select and spi_mosi each pass through a 2-flop synchroniser. Edge detect on the synchronised spi_clk.
- MOSI is sampled on the rising edge, MSB first. MISO is updated on the falling edge.
- Bus FSM states: IDLE, CMD, ADDR, RD, WR, RDMR, WRMR, IGNORE.
  - Synchronised select falling -> CMD.
  - Select rising from any state -> IDLE, with the bit counter cleared. A partially received write byte is discarded.
- Commands:
  - 0x03 -> ADDR -> RD
  - 0x02 -> ADDR -> WR
  - 0x05 -> RDMR
  - 0x01 -> WRMR
  - Anything else -> IGNORE until deselect.
- ADDR: shifts ADDR_BYTES*8 bits, MSB first.
- RD:
  - The byte at addr is fetched on the rising edge that completes the address, and its MSB is driven on the next falling edge.
  - Each following byte is prefetched on the rising edge that samples bit 0 of the current byte.
- WR: each completed byte commits to mem[addr] within 2 clk of its 8th rising edge.
- Address advance after each byte, by mode register bits [7:6]:
  - 00 byte: the next byte goes to IGNORE. Reads drive 0; writes are dropped.
  - 10 page: the low PAGE_LOG2 bits increment and wrap; upper bits are fixed.
  - 01 sequential: increment mod 2^DEPTH_LOG2.
  - 11: treated as sequential.
- RDMR shifts out the mode register repeatedly. WRMR latches the first byte, then goes to IGNORE.
- spi_miso is 0 whenever the state is not RD or RDMR, or the bus is deselected.
- Debug port:
  - dbg_rd or dbg_wr is accepted only when busy = 0 and the other request is low. If both are asserted, both are ignored.
  - An accepted op performs 4 byte accesses at dbg_addr+0..3, wrapping mod 2^DEPTH_LOG2.
  - An SPI commit or prefetch takes the single memory port in a given cycle; the debug access stalls that cycle.
- Memory contents are not cleared by rst.

## Timing
- Reset values:
  - spi_miso 0, dbg_rdata 0, dbg_valid 0, busy 0
  - FSM IDLE, mode register 0x40 (sequential)
  - address and shift registers 0
- Synchroniser plus edge detect: 3 clk from a pin change to the internal event.
- Debug op, unstalled:
  - busy rises the cycle after the request and stays high 4 cycles.
  - dbg_valid pulses in the cycle busy falls.
  - dbg_rdata is stable from that pulse until the next accepted read.
- Each stall adds 1 cycle to the debug op.
- Memory access to miso: a prefetch is issued at a rising edge and is ready in ≤2 clk, which is within the ≥4 clk half period.
- Mid-operation rst: the FSM and debug op abort, with no dbg_valid. A byte already committed stays written.

## Structure
- Shared package spi_sram_pkg holds:
  - command constants CMD_READ 0x03, CMD_WRITE 0x02, CMD_RDMR 0x05, CMD_WRMR 0x01
  - mode encodings MODE_BYTE, MODE_PAGE, MODE_SEQ
  - the bus FSM state enum
- One sub-module, spi_sram_sync_edge: 2-flop synchroniser plus rise/fall detect, instantiated for spi_clk and spi_select.
- Memory is an inferred 2^DEPTH_LOG2 × 8 single-port array, with a priority arbiter in the top module.

## Test plan
- Debug write 0xDEADBEEF at 0x000100, then debug read at 0x000100 -> dbg_rdata 0xDEADBEEF; dbg_valid one cycle; busy high 4 cycles.
- SPI 0x02, address 0x000010, bytes 0x11 0x22 0x33 (sequential) -> debug read at 0x000010 returns 0xXX332211, with the top byte unchanged.
- SPI 0x03 at 0x000FFF, 2 bytes, after a debug preload of 0xAB at 0xFFF and 0xCD at 0x000 -> MISO bytes 0xAB 0xCD (wrap at DEPTH_LOG2 = 12).
- Mode tests:
  - WRMR 0x80 (page), then write 0x01 0x02 starting at 0x00001F -> bytes land at 0x1F and 0x00.
  - RDMR -> 0x80.
- WRMR 0x00 (byte mode), then write 0x55 0x66 at 0x20 -> 0x20 = 0x55, 0x21 unchanged. Reads of a second byte drive 0.
- Deselect after 4 bits of a write data byte -> no memory change. A debug read started during SPI traffic completes with correct data. rst mid-op -> all outputs at reset values and mode 0x40.
